// File: rtl/prbs_pkg.sv
// Shared definitions for the 32-bit PRBS generator/checker pair.
// Polynomial taps, lock-up pattern, default seed, FSM states and the
// feedback function used by both ends of the link.
package prbs_pkg;

    localparam int unsigned PRBS_W      = 32;

    // Feedback taps: new bit = ~(S[31] ^ S[21] ^ S[1] ^ S[0])
    localparam int unsigned PRBS_TAP_A  = 31;
    localparam int unsigned PRBS_TAP_B  = 21;
    localparam int unsigned PRBS_TAP_C  = 1;
    localparam int unsigned PRBS_TAP_D  = 0;

    // XNOR feedback locks up in the all-ones state
    localparam logic [PRBS_W-1:0] PRBS_LOCKUP = '1;
    localparam logic [PRBS_W-1:0] PRBS_SEED   = 32'hBDCA2C92;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    function automatic logic prbs_fb(input logic [PRBS_W-1:0] s);
        return ~(s[PRBS_TAP_A] ^ s[PRBS_TAP_B] ^ s[PRBS_TAP_C] ^ s[PRBS_TAP_D]);
    endfunction

endpackage

// File: rtl/prbs32_ref_lfsr.sv
// Local reference LFSR for the PRBS checker.
// shift_in_i loads the received bit into S[0] (seeding); advance_i shifts the
// LFSR's own predicted bit in (free-running prediction). exp_o is the bit the
// LFSR predicts for the next received bit; lockup_o flags that shifting bit_i
// in would leave the register in the all-ones lock-up state.
module prbs32_ref_lfsr
    import prbs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift_in_i,
    input  logic advance_i,
    input  logic bit_i,
    output logic exp_o,
    output logic lockup_o
);

    logic [PRBS_W-1:0] s_q;
    logic [PRBS_W-1:0] s_d;
    logic              fb;

    // Next register value: seed from the line, or run on the prediction
    always_comb begin
        fb  = prbs_fb(s_q);
        s_d = s_q;
        if (shift_in_i) begin
            s_d = {s_q[PRBS_W-2:0], bit_i};
        end else if (advance_i) begin
            s_d = {s_q[PRBS_W-2:0], fb};
        end
    end

    // LFSR register with synchronous reset to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign exp_o    = fb;
    assign lockup_o = ({s_q[PRBS_W-2:0], bit_i} == PRBS_LOCKUP);

endmodule

// File: rtl/prbs32_checker.sv
// 32-bit PRBS checker: self-synchronises a local LFSR to the received serial
// stream (SEED -> VERIFY -> LOCKED), counts bit errors while locked and drops
// back to SEED when too many errors land inside one window.
// Optional feature: define PRBS_BIT_COUNT_EN to add the bit_count output
// (saturating count of valid bits checked while LOCKED).
module prbs32_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_BITS  = 32,
    parameter int unsigned ERR_THRESH = 8,
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS_BIT_COUNT_EN
    output logic [CNT_W-1:0] bit_count,
`endif
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_W = $clog2(PRBS_W);
    localparam int unsigned RUN_W  = $clog2(LOCK_BITS + 1);
    localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);
    localparam int unsigned WB_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRBS_W - 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_BITS);
    localparam logic [WERR_W-1:0] WERR_MAX  = WERR_W'(ERR_THRESH);
    localparam logic [WB_W-1:0]   WB_LAST   = WB_W'(WINDOW - 1);

    prbs_state_e       state_q, state_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic [RUN_W-1:0]  run_q,   run_d;
    logic [WERR_W-1:0] werr_q,  werr_d;
    logic [WB_W-1:0]   wb_q,    wb_d;
    logic              locked_q, locked_d;
    logic              pulse_q,  pulse_d;
    logic [CNT_W-1:0]  errc_q,   errc_d;
`ifdef PRBS_BIT_COUNT_EN
    logic [CNT_W-1:0]  bitc_q,   bitc_d;
`endif

    logic              lfsr_shift_in;
    logic              lfsr_advance;
    logic              exp_bit;
    logic              lockup;
    logic [WERR_W-1:0] werr_inc;
    logic [RUN_W-1:0]  run_inc;

    prbs32_ref_lfsr u_ref_lfsr (
        .clk        (clk),
        .rst        (rst),
        .shift_in_i (lfsr_shift_in),
        .advance_i  (lfsr_advance),
        .bit_i      (bit_in),
        .exp_o      (exp_bit),
        .lockup_o   (lockup)
    );

    assign werr_inc = werr_q + 1'b1;
    assign run_inc  = run_q + 1'b1;

    // Sync FSM, window bookkeeping and error counters: next-state logic
    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        run_d         = run_q;
        werr_d        = werr_q;
        wb_d          = wb_q;
        pulse_d       = 1'b0;
        errc_d        = errc_q;
        lfsr_shift_in = 1'b0;
        lfsr_advance  = 1'b0;
`ifdef PRBS_BIT_COUNT_EN
        bitc_d        = bitc_q;
`endif

        if (bit_valid) begin
            case (state_q)
                ST_SEED: begin
                    lfsr_shift_in = 1'b1;
                    if (fill_q == FILL_LAST) begin
                        fill_d = '0;
                        // A full fill that lands on the lock-up pattern can never
                        // predict anything useful, so start the fill over.
                        if (!lockup) begin
                            state_d = ST_VERIFY;
                            run_d   = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end

                ST_VERIFY: begin
                    lfsr_advance = 1'b1;
                    if (bit_in == exp_bit) begin
                        run_d = run_inc;
                        if (run_inc == RUN_LOCK) begin
                            state_d = ST_LOCKED;
                            werr_d  = '0;
                            wb_d    = '0;
                        end
                    end else begin
                        state_d = ST_SEED;
                        fill_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    // Only the prediction is shifted in, so a line error never
                    // corrupts the local sequence.
                    lfsr_advance = 1'b1;
                    wb_d         = wb_q + 1'b1;
`ifdef PRBS_BIT_COUNT_EN
                    if (bitc_q != '1) begin
                        bitc_d = bitc_q + 1'b1;
                    end
`endif
                    if (bit_in != exp_bit) begin
                        pulse_d = 1'b1;
                        if (errc_q != '1) begin
                            errc_d = errc_q + 1'b1;
                        end
                        // Threshold check takes priority over the window wrap,
                        // so an error on the wrapping bit still counts.
                        if (werr_inc == WERR_MAX) begin
                            state_d = ST_SEED;
                            fill_d  = '0;
                            werr_d  = '0;
                            wb_d    = '0;
                        end else if (wb_q == WB_LAST) begin
                            werr_d = '0;
                        end else begin
                            werr_d = werr_inc;
                        end
                    end else if (wb_q == WB_LAST) begin
                        werr_d = '0;
                    end
                end

                default: begin
                    state_d = ST_SEED;
                    fill_d  = '0;
                end
            endcase
        end

        if (clear) begin
            errc_d = '0;
`ifdef PRBS_BIT_COUNT_EN
            bitc_d = '0;
`endif
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and counter registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEED;
            fill_q   <= '0;
            run_q    <= '0;
            werr_q   <= '0;
            wb_q     <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            werr_q   <= werr_d;
            wb_q     <= wb_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            errc_q   <= errc_d;
        end
    end

`ifdef PRBS_BIT_COUNT_EN
    // Saturating count of bits checked while locked
    always_ff @(posedge clk) begin
        if (rst) begin
            bitc_q <= '0;
        end else begin
            bitc_q <= bitc_d;
        end
    end

    assign bit_count = bitc_q;
`endif

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_prbs32_checker.sv
// Self-checking bench for prbs32_checker: directed lock/error scenarios plus a
// randomized run, all against a queue-based reference model of the checker.
module tb_prbs32_checker;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
`ifdef PRBS_BIT_COUNT_EN
    logic [CNT_W-1:0] bit_count;
`endif

    always #5 clk = ~clk;

    prbs32_checker #(
        .LOCK_BITS  (32),
        .ERR_THRESH (8),
        .WINDOW     (256),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
`ifdef PRBS_BIT_COUNT_EN
        .bit_count (bit_count),
`endif
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;

    // Generator history (last 32 emitted bits, oldest first)
    bit gq[$];
    // Reference model state
    bit          mh[$];
    int          m_mode;   // 0 seeding, 1 verifying, 2 locked
    int          m_run;
    int          m_wbits;
    int          m_werr;
    int unsigned m_errc;
    int unsigned m_bitc;
    bit          m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next bit of the sequence from the last 32 bits (oldest first):
    // S[31]=q[0], S[21]=q[10], S[1]=q[30], S[0]=q[31]
    function automatic bit pred(input bit q[$]);
        return ~(q[0] ^ q[10] ^ q[30] ^ q[31]);
    endfunction

    function automatic bit gen_next();
        bit b;
        b = pred(gq);
        gq.push_back(b);
        void'(gq.pop_front());
        return b;
    endfunction

    task automatic gen_seed();
        logic [31:0] s;
        s = 32'hBDCA2C92;
        gq.delete();
        for (int i = 31; i >= 0; i--) gq.push_back(s[i]);
    endtask

    task automatic model_reset();
        m_mode = 0; mh.delete(); m_run = 0; m_wbits = 0; m_werr = 0;
        m_errc = 0; m_bitc = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit b, input bit v, input bit c);
        bit e;
        int ones;
        m_pulse = 0;
        if (v) begin
            case (m_mode)
                0: begin
                    mh.push_back(b);
                    if (mh.size() == 32) begin
                        ones = 0;
                        foreach (mh[i]) ones += int'(mh[i]);
                        if (ones == 32) mh.delete();
                        else begin m_mode = 1; m_run = 0; end
                    end
                end
                1: begin
                    e = pred(mh); mh.push_back(e); void'(mh.pop_front());
                    if (b == e) begin
                        m_run++;
                        if (m_run == 32) begin m_mode = 2; m_wbits = 0; m_werr = 0; end
                    end else begin
                        m_mode = 0; mh.delete();
                    end
                end
                default: begin
                    e = pred(mh); mh.push_back(e); void'(mh.pop_front());
                    m_wbits++;
                    if (m_bitc < 65535) m_bitc++;
                    if (b != e) begin
                        m_pulse = 1;
                        if (m_errc < 65535) m_errc++;
                        m_werr++;
                    end
                    if (m_werr == 8) begin m_mode = 0; mh.delete(); end
                    else if (m_wbits == 256) begin m_wbits = 0; m_werr = 0; end
                end
            endcase
        end
        if (c) begin m_errc = 0; m_bitc = 0; end
    endtask

    task automatic step(input bit b, input bit v, input bit c);
        bit_in = b; bit_valid = v; clear = c;
        @(posedge clk);
        #1;
        model_step(b, v, c);
        check("locked",    {31'd0, locked},    {31'd0, (m_mode == 2)});
        check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
        check("err_count", {16'd0, err_count}, m_errc);
`ifdef PRBS_BIT_COUNT_EN
        check("bit_count", {16'd0, bit_count}, m_bitc);
`endif
    endtask

    // One cycle of generator stream; inv flips the transmitted bit
    task automatic feed(input bit inv, input bit v, input bit c);
        bit b;
        if (v) b = gen_next() ^ inv;
        else   b = 1'($urandom_range(0, 1));
        step(b, v, c);
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; clear = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        gen_seed();
        check("rst_locked", {31'd0, locked},    32'd0);
        check("rst_pulse",  {31'd0, err_pulse}, 32'd0);
        check("rst_errc",   {16'd0, err_count}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int vc;
        bit v;

        do_reset();

        // Clean stream: lock exactly on the 64th valid bit
        for (int i = 1; i <= 64; i++) begin
            feed(1'b0, 1'b1, 1'b0);
            if (i == 63) check("lock63", {31'd0, locked}, 32'd0);
            if (i == 64) check("lock64", {31'd0, locked}, 32'd1);
        end
        check("lock_errc", {16'd0, err_count}, 32'd0);

        // Single inverted bit while locked
        repeat (20) feed(1'b0, 1'b1, 1'b0);
        feed(1'b1, 1'b1, 1'b0);
        check("single_pulse",  {31'd0, err_pulse}, 32'd1);
        check("single_errc",   {16'd0, err_count}, 32'd1);
        check("single_locked", {31'd0, locked},    32'd1);
        feed(1'b0, 1'b1, 1'b0);
        check("single_pulse_end", {31'd0, err_pulse}, 32'd0);

        // Move into a fresh window, clear, then 8 errors within one window
        repeat (300) feed(1'b0, 1'b1, 1'b0);
        feed(1'b0, 1'b0, 1'b1);
        check("clear_errc", {16'd0, err_count}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (9) feed(1'b0, 1'b1, 1'b0);
            feed(1'b1, 1'b1, 1'b0);
            if (k == 6) check("seven_locked", {31'd0, locked}, 32'd1);
        end
        check("burst_unlock", {31'd0, locked},    32'd0);
        check("burst_errc",   {16'd0, err_count}, 32'd8);
        for (int i = 1; i <= 64; i++) begin
            feed(1'b0, 1'b1, 1'b0);
            if (i == 63) check("relock63", {31'd0, locked}, 32'd0);
            if (i == 64) check("relock64", {31'd0, locked}, 32'd1);
        end

        // 4 + 3 errors spread over two windows: stays locked
        feed(1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 2; w++) begin
            for (int i = 1; i <= 256; i++) begin
                feed((i % 30 == 0) && (i <= ((w == 0) ? 120 : 90)), 1'b1, 1'b0);
            end
        end
        check("spread_locked", {31'd0, locked},    32'd1);
        check("spread_errc",   {16'd0, err_count}, 32'd7);

        // Error coincident with clear: clear wins
        feed(1'b1, 1'b1, 1'b1);
        check("clr_err_errc",  {16'd0, err_count}, 32'd0);
        check("clr_err_pulse", {31'd0, err_pulse}, 32'd1);

        // Reset while locked
        feed(1'b1, 1'b1, 1'b0);
        check("pre_rst_errc", {16'd0, err_count}, 32'd1);
        do_reset();

        // All-ones stream never leaves seeding
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b0);
        check("ones_locked", {31'd0, locked}, 32'd0);

        // 50% valid: lock timing counts valid bits only
        do_reset();
        vc = 0;
        for (int it = 0; it < 1000 && vc < 64; it++) begin
            v = 1'($urandom_range(0, 1));
            feed(1'b0, v, 1'b0);
            if (v) begin
                vc++;
                if (vc == 63) check("vlock63", {31'd0, locked}, 32'd0);
                if (vc == 64) check("vlock64", {31'd0, locked}, 32'd1);
            end
        end
        check("vlock_budget", vc, 32'd64);

        // Randomized run: sparse errors, gaps and occasional clears
        for (int i = 0; i < 4000; i++) begin
            feed(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
